// File: rtl/seq_detect_param.sv
// Runtime-programmable Mealy serial-pattern detector with valid-qualified input.
// Optional saturating match counter enabled by SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param #(
  parameter int unsigned          MAX_LEN = 8,
  parameter int unsigned          LEN_W   = 4,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [MAX_LEN-1:0]   RST_PAT = MAX_LEN'(8'b0000_1101),
  parameter logic [LEN_W-1:0]     RST_LEN = LEN_W'(4),
  parameter logic                 RST_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               y,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned HIST_W = MAX_LEN - 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

  logic [HIST_W-1:0]  hist,    hist_nxt;
  logic [LEN_W-1:0]   fill,    fill_nxt;
  logic [MAX_LEN-1:0] cfg_pat, cfg_pat_nxt;
  logic [LEN_W-1:0]   cfg_len, cfg_len_nxt;
  logic               cfg_ovl, cfg_ovl_nxt;
  logic               cfg_err_nxt;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0]   cnt, cnt_nxt;
`endif

  assign win = {hist, din};

  // Only the low cfg_len bits of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (32'(cfg_len) > 32'(i));
    end
  end

  // Enough history (plus the current bit) to cover the active pattern.
  assign fill_ok = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(cfg_len);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      cfg_pat <= RST_PAT;
      cfg_len <= RST_LEN;
      cfg_ovl <= RST_OVL;
      cfg_err <= 1'b0;
`ifdef SEQ_DETECT_MATCH_CNT_EN
      cnt     <= '0;
`endif
    end else begin
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      cfg_pat <= cfg_pat_nxt;
      cfg_len <= cfg_len_nxt;
      cfg_ovl <= cfg_ovl_nxt;
      cfg_err <= cfg_err_nxt;
`ifdef SEQ_DETECT_MATCH_CNT_EN
      cnt     <= cnt_nxt;
`endif
    end
  end

  // Next-state logic; cfg_load wins over a valid bit in the same cycle
  always_comb begin
    hist_nxt    = hist;
    fill_nxt    = fill;
    cfg_pat_nxt = cfg_pat;
    cfg_len_nxt = cfg_len;
    cfg_ovl_nxt = cfg_ovl;
    cfg_err_nxt = cfg_err;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    cnt_nxt     = cnt;
`endif
    if (cfg_load) begin
      cfg_pat_nxt = pattern;
      cfg_len_nxt = pat_len;
      cfg_ovl_nxt = overlap;
      hist_nxt    = '0;
      fill_nxt    = '0;
      cfg_err_nxt = (pat_len == '0) || (32'(pat_len) > 32'(MAX_LEN));
`ifdef SEQ_DETECT_MATCH_CNT_EN
      cnt_nxt     = '0;
`endif
    end else if (din_valid) begin
      hist_nxt = win[HIST_W-1:0];
      fill_nxt = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
      // Non-overlap: forget the matched window so its bits cannot be reused
      if (y && !cfg_ovl) begin
        fill_nxt = '0;
      end
`ifdef SEQ_DETECT_MATCH_CNT_EN
      if (y && (cnt != '1)) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
`endif
    end
  end

  // Mealy output
  always_comb begin
    y = 1'b0;
    if (din_valid && !cfg_load && !cfg_err && fill_ok &&
        (((win ^ cfg_pat) & mask) == '0)) begin
      y = 1'b1;
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the detector rules.
module tb_seq_detect_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic               overlap = 1'b0;
  logic               y, y2, cfg_err, cfg_err2;
  logic [7:0]         match_cnt;
  logic [1:0]         match_cnt2;

  int checks = 0;
  int errors = 0;
  logic [31:0] ymask;

  // Reference model state: valid bits seen since the last clear point
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_err;
  int         m_cnt, m_cnt2;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .y(y), .cfg_err(cfg_err), .match_cnt(match_cnt));

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .y(y2), .cfg_err(cfg_err2), .match_cnt(match_cnt2));

  always #5 clk = ~clk;

  function automatic bit model_y(input bit d, input bit v, input bit ld);
    int n;
    if (!v || ld || m_err) return 1'b0;
    n = q.size();
    if (n + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len - 1; k++)
      if (q[n - (m_len - 1) + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return (d == m_pat[0]);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat = 8'h0D; m_len = 4; m_ovl = 1'b1; m_err = 1'b0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic check_outputs(input bit ey);
    int ec, ec2;
    ec  = CNT_EN ? m_cnt  : 0;
    ec2 = CNT_EN ? m_cnt2 : 0;
    checks++;
    assert (y === ey) else begin errors++; $error("FAIL y obs=%b exp=%b t=%0t", y, ey, $time); end
    checks++;
    assert (y2 === ey) else begin errors++; $error("FAIL y2 obs=%b exp=%b t=%0t", y2, ey, $time); end
    checks++;
    assert (cfg_err === m_err) else begin errors++; $error("FAIL cfg_err obs=%b exp=%b t=%0t", cfg_err, m_err, $time); end
    checks++;
    assert (match_cnt === 8'(ec)) else begin errors++; $error("FAIL match_cnt obs=%0d exp=%0d t=%0t", match_cnt, ec, $time); end
    checks++;
    assert (match_cnt2 === 2'(ec2)) else begin errors++; $error("FAIL match_cnt2 obs=%0d exp=%0d t=%0t", match_cnt2, ec2, $time); end
  endtask

  // One clock: drive at negedge, check before posedge, update model after it
  task automatic step(input bit d, input bit v, input bit ld,
                      input logic [7:0] p, input int l, input bit o);
    bit ey;
    din = d; din_valid = v; cfg_load = ld;
    pattern = p; pat_len = 4'(l); overlap = o;
    #1;
    ey = model_y(d, v, ld);
    check_outputs(ey);
    if (v && !ld) ymask = {ymask[30:0], y};
    @(posedge clk);
    if (ld) begin
      q.delete();
      m_pat = p; m_len = l; m_ovl = o;
      m_err = (l == 0) || (l > int'(MAX_LEN));
      m_cnt = 0; m_cnt2 = 0;
    end else if (v) begin
      if (ey) begin
        if (m_cnt  < 255) m_cnt++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
      if (ey && !m_ovl) q.delete();
      else begin
        q.push_back(d);
        if (q.size() > 16) void'(q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit o);
    step(1'b0, 1'b0, 1'b1, p, l, o);
  endtask

  task automatic feed(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) step(s[i], 1'b1, 1'b0, m_pat, m_len, m_ovl);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, m_pat, m_len, m_ovl);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    model_reset();
    #2;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin errors++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v); end
  endtask

  initial begin
    do_reset();

    // Reset defaults: 1101, overlapping
    ymask = '0;
    feed(32'b11011011101, 11);
    chk("ovl_stream", ymask & 32'h7FF, 32'b00010010001);
    chk("ovl_cnt", 32'(match_cnt), CNT_EN ? 32'd3 : 32'd0);

    load(8'h0D, 4, 1'b0);
    ymask = '0;
    feed(32'b11011011101, 11);
    chk("novl_stream", ymask & 32'h7FF, 32'b00010000001);
    chk("novl_cnt", 32'(match_cnt), CNT_EN ? 32'd2 : 32'd0);

    load(8'h05, 3, 1'b1);
    ymask = '0;
    feed(32'b10101, 5);
    chk("p101_ovl", ymask & 32'h1F, 32'b00101);
    load(8'h05, 3, 1'b0);
    ymask = '0;
    feed(32'b10101, 5);
    chk("p101_novl", ymask & 32'h1F, 32'b00100);

    // Bubbles between bits 2 and 3
    load(8'h0D, 4, 1'b1);
    ymask = '0;
    feed(32'b11, 2);
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, m_pat, m_len, m_ovl);
    feed(32'b01, 2);
    chk("bubble", ymask & 32'hF, 32'b0001);

    // Illegal length
    load(8'h0D, 0, 1'b1);
    idle();
    chk("err_set", 32'(cfg_err), 32'd1);
    ymask = '0;
    feed(32'b11011101, 8);
    chk("err_noy", ymask & 32'hFF, 32'd0);
    load(8'h0D, 4, 1'b1);
    idle();
    chk("err_clr", 32'(cfg_err), 32'd0);

    // Reset mid-pattern, then cfg_load colliding with the final bit
    feed(32'b110, 3);
    do_reset();
    ymask = '0;
    feed(32'b1, 1);
    chk("rst_mid", ymask & 32'h1, 32'd0);
    feed(32'b110, 3);
    step(1'b1, 1'b1, 1'b1, 8'h0D, 4, 1'b1);
    ymask = '0;
    feed(32'b1, 1);
    chk("load_discard", ymask & 32'h1, 32'd0);

    // Five overlapping matches: 2-bit counter saturates
    load(8'h0D, 4, 1'b1);
    feed(32'b1101101101101101, 16);
    chk("cnt8", 32'(match_cnt), CNT_EN ? 32'd5 : 32'd0);
    chk("cnt2_sat", 32'(match_cnt2), CNT_EN ? 32'd3 : 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        int l;
        l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(1, 4));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             8'($urandom), l, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), 1'b0,
             8'($urandom), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised Mealy serial-pattern detector, successor to the fixed-pattern detector. Pattern, pattern length and overlap mode are runtime-programmable, up to MAX_LEN bits. Input is qualified by a valid strobe, and a saturating match counter is optional. Sits on a serial bit stream feeding control/status logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of pat_len; must hold MAX_LEN (>= $clog2(MAX_LEN+1))
CNT_W, 8, match counter width
RST_PAT, 8'b0000_1101, pattern loaded at reset (MAX_LEN bits)
RST_LEN, 4, pattern length loaded at reset
RST_OVL, 1, overlap mode loaded at reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
din  in  1  serial data bit
din_valid  in  1  din sampled only when high
cfg_load  in  1  one-cycle pulse: latch pattern/pat_len/overlap, clear history
pattern  in  MAX_LEN  pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last
pat_len  in  LEN_W  active length, legal 1..MAX_LEN
overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
y  out  1  Mealy match output (combinational from din/din_valid/state)
cfg_err  out  1  registered; high while latched length is illegal
match_cnt  out  CNT_W  saturating match count (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): history shift register = 0; fill count = 0; cfg regs = RST_PAT/RST_LEN/RST_OVL; cfg_err = 0; match_cnt = 0; y = 0 (no valid history).
- State: hist[MAX_LEN-2:0] shift register (newest bit at [0]); fill counter 0..MAX_LEN-1, saturating; latched cfg_pat, cfg_len, cfg_ovl.
- Match (combinational): y = din_valid & !cfg_load & !cfg_err & (fill >= cfg_len-1) & ({hist, din} low cfg_len bits == cfg_pat low cfg_len bits). cfg_len = 1 compares din alone.
- Latency: y asserts in the same cycle the final pattern bit is presented; no pipeline delay.
- On clk with din_valid & !cfg_load: hist <= {hist, din}; fill <= min(fill+1, MAX_LEN-1).
- Non-overlap mode (cfg_ovl = 0): on a match cycle, fill <= 0, so no bit of a matched window contributes to the next match. Overlap mode: fill advances normally.
- din_valid low: hist, fill and y hold/are 0 respectively; bubbles do not break an in-progress match.
- cfg_load: latches pattern/pat_len/overlap; clears hist and fill; cfg_err <= (pat_len == 0 or pat_len > MAX_LEN). Takes priority over din_valid in the same cycle: the bit is discarded and y = 0. New config governs from the next cycle.
- Illegal length: y is held 0 and the counter does not advance until a legal cfg_load.
- Reset mid-stream: all history lost immediately; detection restarts from empty.

Optional Feature:
SEQ_DETECT_MATCH_CNT_EN:
- Defined: match_cnt increments by 1 on each clock where y = 1 and saturates at all-ones (no wrap). It is cleared by reset and by cfg_load.
- Undefined: the counter register is not built and match_cnt is tied to 0.

Test Plan:
- Reset defaults (1101, len 4, overlap), stream 11011011101 MSB-first -> y high on bits 4, 7, 11; match_cnt = 3.
- cfg_load overlap=0, same pattern/stream -> y high on bits 4, 11 only; match_cnt = 2.
- cfg_load pattern 101, len 3: stream 10101 with overlap=1 -> y on bits 3, 5; with overlap=0 -> y on bit 3 only.
- Len 4 overlap, stream 1101 with din_valid low for 3 cycles between bits 2 and 3 -> y still high on bit 4; no y during bubbles.
- cfg_load pat_len = 0 -> cfg_err = 1 next cycle, y never asserts on any stream; legal cfg_load clears cfg_err.
- Assert rst_n low after 3 bits of 1101 and release, then feed 1 -> y = 0. Also assert cfg_load together with the 4th bit -> y = 0 and the bit is discarded. Counter test: CNT_W = 2 with 5 matches -> match_cnt = 3.
